multi_channel_clock_gater: RTL and testbench

- Parametrised N-channel clock gater: per-channel asynchronous enable requests, SYNC_STAGES-deep synchronisers, and a per-channel FSM with a programmable turn-off hold-off.
- Glitch-free latch-based gating of one shared clock into N_CH gated clocks, with a per-channel "on" status and an aggregate count of open channels.
- Sits between the power/activity controller and the core clock trees.

---
 rtl/multi_channel_clock_gater.sv | 164 ++++++++++++++++
 tb/tb_multi_channel_clock_gater.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_clock_gater.sv
// N-channel glitch-free clock gater: synchronised requests, per-channel hold-off FSM, latch-based gating.
// Optional scan override port test_en is enabled by defining MULTI_CLOCK_GATER_TEST_EN.
module multi_channel_clock_gater #(
    parameter int  N_CH        = 4,
    parameter int  SYNC_STAGES = 2,
    parameter int  HOLD_CYCLES = 4,
    localparam int CNT_W       = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1,
    localparam int ON_W        = $clog2(N_CH + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] async_clk_en,
`ifdef MULTI_CLOCK_GATER_TEST_EN
    input  logic            test_en,
`endif
    output logic [N_CH-1:0] gated_clk,
    output logic [N_CH-1:0] gated_clk_is_on,
    output logic [ON_W-1:0] on_count,
    output logic            all_off
);

    // state    | meaning
    // ST_OFF   | gate closed, waiting for a synchronised request
    // ST_ON    | gate open, request still present
    // ST_DRAIN | request gone, gate held open for HOLD_CYCLES more cycles
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_ON    = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

    logic [N_CH-1:0]  sync_q [SYNC_STAGES];
    logic [N_CH-1:0]  sync_en;

    state_e           state_q [N_CH];
    state_e           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];
    logic [N_CH-1:0]  en_q;
    logic [N_CH-1:0]  en_d;

    logic [N_CH-1:0]  latch_d;
    logic [N_CH-1:0]  latch_q;

    logic [N_CH-1:0]  is_on_q;
    logic [ON_W-1:0]  on_count_q;
    logic [ON_W-1:0]  on_count_d;
    logic             all_off_q;
    logic             all_off_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= async_clk_en;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_en = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_OFF;
                cnt_q[i]   <= '0;
            end
            en_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            en_q <= en_d;
        end
    end

    always_comb begin
        en_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (sync_en[i]) begin
                        state_d[i] = ST_ON;
                    end
                end
                ST_ON: begin
                    if (!sync_en[i]) begin
                        if (HOLD_CYCLES == 0) begin
                            state_d[i] = ST_OFF;
                        end else begin
                            state_d[i] = ST_DRAIN;
                            cnt_d[i]   = HOLD_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    // A re-request returns straight to ON so the pulse train has no gap.
                    if (sync_en[i]) begin
                        state_d[i] = ST_ON;
                    end else if (cnt_q[i] == '0) begin
                        state_d[i] = ST_OFF;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                end
            endcase
            en_d[i] = (state_d[i] != ST_OFF);
        end
    end

`ifdef MULTI_CLOCK_GATER_TEST_EN
    assign latch_d = en_q | {N_CH{test_en}};
`else
    assign latch_d = en_q;
`endif

    // Transparent only while clk is low, so the enable is frozen for the whole high phase.
    always_latch begin
        if (reset) begin
            latch_q <= '0;
        end else if (!clk) begin
            latch_q <= latch_d;
        end
    end

    assign gated_clk = {N_CH{clk}} & latch_q;

    always_comb begin
        on_count_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            on_count_d = on_count_d + ON_W'(latch_q[i]);
        end
        all_off_d = (on_count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            is_on_q    <= '0;
            on_count_q <= '0;
            all_off_q  <= 1'b1;
        end else begin
            is_on_q    <= latch_q;
            on_count_q <= on_count_d;
            all_off_q  <= all_off_d;
        end
    end

    assign gated_clk_is_on = is_on_q;
    assign on_count        = on_count_q;
    assign all_off         = all_off_q;

endmodule

// File: tb/tb_multi_channel_clock_gater.sv
// Scoreboard bench: two gaters (hold 4 and hold 0) share stimulus; a sliding-window request model predicts status.
module tb_multi_channel_clock_gater;

    localparam int N_CH = 4;
    localparam int SYNC = 2;
    localparam int HOLD = 4;
    localparam int ON_W = $clog2(N_CH + 1);
    localparam int HALF = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N_CH-1:0] async_clk_en = '0;
`ifdef MULTI_CLOCK_GATER_TEST_EN
    logic            test_en = 1'b0;
`endif

    logic [N_CH-1:0] gated_clk, gated_clk_is_on;
    logic [ON_W-1:0] on_count;
    logic            all_off;
    logic [N_CH-1:0] gated_clk0, gated_clk_is_on0;
    logic [ON_W-1:0] on_count0;
    logic            all_off0;

    multi_channel_clock_gater #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD)) dut (
        .clk             (clk),
        .reset           (reset),
        .async_clk_en    (async_clk_en),
`ifdef MULTI_CLOCK_GATER_TEST_EN
        .test_en         (test_en),
`endif
        .gated_clk       (gated_clk),
        .gated_clk_is_on (gated_clk_is_on),
        .on_count        (on_count),
        .all_off         (all_off)
    );

    multi_channel_clock_gater #(.N_CH(N_CH), .SYNC_STAGES(SYNC), .HOLD_CYCLES(0)) dut0 (
        .clk             (clk),
        .reset           (reset),
        .async_clk_en    (async_clk_en),
`ifdef MULTI_CLOCK_GATER_TEST_EN
        .test_en         (test_en),
`endif
        .gated_clk       (gated_clk0),
        .gated_clk_is_on (gated_clk_is_on0),
        .on_count        (on_count0),
        .all_off         (all_off0)
    );

    always #HALF clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N_CH-1:0] on4;
        logic [ON_W-1:0] cnt4;
        logic            off4;
        logic [N_CH-1:0] on0;
        logic [ON_W-1:0] cnt0;
        logic            off0;
    } exp_t;

    exp_t            exp_q[$];
    logic [N_CH-1:0] hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, want, $time);
        end
    endtask

    // A gate is open in the high phase after edge e iff the request was seen by the
    // first synchroniser stage at any edge in [e-1-SYNC-hold, e-1-SYNC].
    function automatic logic [N_CH-1:0] window(input int hold);
        logic [N_CH-1:0] acc;
        int n;
        acc = '0;
        n = hist.size();
        for (int t = 0; t <= hold; t++) begin
            int idx;
            idx = n - 1 - (1 + SYNC + t);
            if (idx >= 0) acc = acc | hist[idx];
        end
        return acc;
    endfunction

    function automatic logic [ON_W-1:0] popc(input logic [N_CH-1:0] v);
        logic [ON_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_CH; i++) c = c + ON_W'(v[i]);
        return c;
    endfunction

    // Called at a negedge: drive the request for the coming edge, predict that edge, wait one cycle.
    task automatic step(input logic [N_CH-1:0] req, input logic te);
        exp_t x;
        async_clk_en = req;
`ifdef MULTI_CLOCK_GATER_TEST_EN
        test_en = te;
`endif
        hist.push_back(req);
        if (hist.size() > 64) void'(hist.pop_front());
        x.on4  = window(HOLD) | {N_CH{te}};
        x.cnt4 = popc(x.on4);
        x.off4 = (x.cnt4 == '0);
        x.on0  = window(0) | {N_CH{te}};
        x.cnt0 = popc(x.on0);
        x.off0 = (x.cnt0 == '0);
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic chk_reset();
        chk("rst_gated",    32'(gated_clk),        0);
        chk("rst_is_on",    32'(gated_clk_is_on),  0);
        chk("rst_count",    32'(on_count),         0);
        chk("rst_all_off",  32'(all_off),          1);
        chk("rst_gated0",   32'(gated_clk0),       0);
        chk("rst_is_on0",   32'(gated_clk_is_on0), 0);
        chk("rst_count0",   32'(on_count0),        0);
        chk("rst_all_off0", 32'(all_off0),         1);
    endtask

    // Monitor: compares each predicted edge, sampled 1 time unit into the high phase.
    initial begin
        exp_t w;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("is_on_h4",    32'(gated_clk_is_on),  32'(w.on4));
                chk("count_h4",    32'(on_count),         32'(w.cnt4));
                chk("all_off_h4",  32'(all_off),          32'(w.off4));
                chk("gated_hi_h4", 32'(gated_clk),        32'(w.on4));
                chk("is_on_h0",    32'(gated_clk_is_on0), 32'(w.on0));
                chk("count_h0",    32'(on_count0),        32'(w.cnt0));
                chk("all_off_h0",  32'(all_off0),         32'(w.off0));
                chk("gated_hi_h0", 32'(gated_clk0),       32'(w.on0));
            end
        end
    end

    // Glitch checker: every gated pulse starts with clk high and lasts exactly one clk high phase.
    logic [2*N_CH-1:0] gc_all;
    logic [2*N_CH-1:0] gc_prev = '0;
    time               rise_t [2*N_CH];
    assign gc_all = {gated_clk0, gated_clk};

    always @(gc_all) begin
        for (int i = 0; i < 2*N_CH; i++) begin
            if (gc_all[i] === 1'b1 && gc_prev[i] !== 1'b1) begin
                chk("rise_on_clk_high", 32'(clk), 1);
                rise_t[i] = $time;
            end else if (gc_all[i] !== 1'b1 && gc_prev[i] === 1'b1 && !reset) begin
                chk("pulse_width", 32'($time - rise_t[i]), HALF);
            end
        end
        gc_prev = gc_all;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_CH-1:0] v;
        int n;
        reset = 1'b1;
        async_clk_en = '0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk_reset();
        end
        @(negedge clk);
        reset = 1'b0;
        hist.delete();

        // turn-on then turn-off with hold
        repeat (10) step(4'b0001, 1'b0);
        repeat (12) step(4'b0000, 1'b0);

        // re-request inside the hold window
        repeat (8)  step(4'b0001, 1'b0);
        repeat (3)  step(4'b0000, 1'b0);
        repeat (8)  step(4'b0001, 1'b0);
        repeat (12) step(4'b0000, 1'b0);

        // simultaneous channels, then one drops
        repeat (8)  step(4'b1110, 1'b0);
        repeat (12) step(4'b1010, 1'b0);
        repeat (12) step(4'b0000, 1'b0);

        for (int s = 0; s < 60; s++) begin
            v = N_CH'($urandom_range(0, (1 << N_CH) - 1));
            n = $urandom_range(1, 8);
            repeat (n) step(v, 1'b0);
        end
        repeat (12) step(4'b0000, 1'b0);

        // reset in the middle of a high phase with every channel open
        repeat (10) step(4'b1111, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_immediate",  32'(gated_clk),  0);
        chk("rst_immediate0", 32'(gated_clk0), 0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_reset();
        end
        @(negedge clk);
        reset = 1'b0;
        hist.delete();
        repeat (10) step(4'b1111, 1'b0);
        repeat (12) step(4'b0000, 1'b0);

`ifdef MULTI_CLOCK_GATER_TEST_EN
        repeat (5) step(4'b0000, 1'b1);
        repeat (5) step(4'b0000, 1'b0);
        for (int s = 0; s < 30; s++) begin
            v = N_CH'($urandom_range(0, (1 << N_CH) - 1));
            n = $urandom_range(1, 6);
            repeat (n) step(v, 1'($urandom_range(0, 1)));
        end
        repeat (12) step(4'b0000, 1'b0);
`endif

        @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
